// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath: ALU opcodes, controller
// state encoding and status flag bit positions.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_LSR = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_ASR = 4'hA;
  localparam logic [3:0] OP_ILL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_ROL = 4'hD;
  localparam logic [3:0] OP_PSA = 4'hE;
  localparam logic [3:0] OP_PSB = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Merge freshly computed ALU flags into the stored status by opcode class.
  function automatic logic [3:0] updateFlags(input logic [3:0] op,
                                             input logic [3:0] cur,
                                             input logic [3:0] alu);
    logic [3:0] f;
    f = cur;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: f = alu;
      OP_LSR, OP_LSL, OP_ASR, OP_ROR, OP_ROL: begin
        f[FLAG_N] = alu[FLAG_N];
        f[FLAG_Z] = alu[FLAG_Z];
        f[FLAG_C] = alu[FLAG_C];
      end
      OP_ILL: f = cur;
      default: begin
        f[FLAG_N] = alu[FLAG_N];
        f[FLAG_Z] = alu[FLAG_Z];
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// Four 8-bit registers with a dual-address operand read port, a debug read
// port and a single write port shared by writeback and host loads.
module reg_file_4x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_en_i,
  input  logic [1:0] wb_addr_i,
  input  logic [7:0] wb_data_i,
  input  logic       ld_en_i,
  input  logic [1:0] ld_addr_i,
  input  logic [7:0] ld_data_i,
  input  logic [1:0] rd_addr_a_i,
  input  logic [1:0] rd_addr_b_i,
  input  logic [1:0] dbg_addr_i,
  output logic [7:0] rd_data_a_o,
  output logic [7:0] rd_data_b_o,
  output logic [7:0] dbg_data_o
);

  logic [7:0] regs_q [4];

  // Writeback wins over a host load if both are ever requested together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
    end else if (wb_en_i) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end else if (ld_en_i) begin
      regs_q[ld_addr_i] <= ld_data_i;
    end
  end

  assign rd_data_a_o = regs_q[rd_addr_a_i];
  assign rd_data_b_o = regs_q[rd_addr_b_i];
  assign dbg_data_o  = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_ctrl.sv
// Execution controller: accepts register-register instructions, drives the
// external ALU, writes results back and maintains the N/Z/C/V status.
module alu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  input  logic [7:0] alu_y,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic [3:0] flags,
  output logic       done,
  output logic       illegal
);

  state_e     state_q;
  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] opA_q, opB_q;
  logic [7:0] res_q;
  logic [3:0] resFlags_q;
  logic [3:0] flags_q, flags_d;
  logic       done_q, illegal_q;

  logic [7:0] rdDataA, rdDataB;
  logic       wbEn, ldEn;

  assign wbEn = (state_q == ST_WB) && (op_q != OP_ILL);
  assign ldEn = ld_en && (state_q == ST_IDLE);

  reg_file_4x8 u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_en_i     (wbEn),
    .wb_addr_i   (rd_q),
    .wb_data_i   (res_q),
    .ld_en_i     (ldEn),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data),
    .rd_addr_a_i (instr[3:2]),
    .rd_addr_b_i (instr[1:0]),
    .dbg_addr_i  (dbg_addr),
    .rd_data_a_o (rdDataA),
    .rd_data_b_o (rdDataB),
    .dbg_data_o  (dbg_data)
  );

  assign flags_d = updateFlags(op_q, flags_q, resFlags_q);

  // Operands are latched at accept, so a same-cycle host load is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 4'h0;
      rd_q       <= 2'd0;
      opA_q      <= 8'h00;
      opB_q      <= 8'h00;
      res_q      <= 8'h00;
      resFlags_q <= 4'h0;
      flags_q    <= 4'h0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q    <= instr[7:4];
            rd_q    <= instr[3:2];
            opA_q   <= rdDataA;
            opB_q   <= rdDataB;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q      <= alu_y;
          resFlags_q <= {alu_n, alu_z, alu_c, alu_v};
          done_q     <= 1'b1;
          illegal_q  <= (op_q == OP_ILL);
          state_q    <= ST_WB;
        end
        ST_WB: begin
          flags_q   <= flags_d;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_a       = opA_q;
  assign alu_b       = opB_q;
  assign alu_op      = op_q;
  assign alu_cin     = flags_q[FLAG_C];
  assign flags       = flags_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule
